// File: rtl/btn_debounce_pulse.sv
// Per-button conditioning: 2-FF synchronizer, debounce FSM, and a single-cycle press
// strobe with optional auto-repeat, feeding the nibble up/down counter.
module btn_debounce_pulse #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int unsigned CNT_MAX_A = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StDebPress,
        StHeld,
        StRepeat,
        StDebRel
    } state_e;

    state_e           state_q [N_BTN];
    state_e           state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Every state change clears the counter, so it never needs to wrap.
    always_comb begin
        pulse_d = '0;
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StDebPress;
                        cnt_d[i]   = '0;
                    end
                end
                StDebPress: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                StHeld: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StDebRel;
                        cnt_d[i]   = '0;
                    end else if (repeat_en[i]) begin
                        if (cnt_q[i] == DLY_LAST) begin
                            state_d[i] = StRepeat;
                            cnt_d[i]   = '0;
                            pulse_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                StRepeat: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StDebRel;
                        cnt_d[i]   = '0;
                    end else if (!repeat_en[i]) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == PER_LAST) begin
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                StDebRel: begin
                    // Bounce back to pressed is not a new press.
                    if (sync2_q[i]) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed scenarios plus random stimulus, all checked every
// cycle against a run-length reference model of the debounce and repeat rules.
module tb_btn_debounce_pulse;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    int total = 0;
    int bad = 0;

    // Reference model state: synchronizer copy, accepted level, run lengths.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pls = '0;
    int m_dc [N];
    int m_r  [N];

    btn_debounce_pulse #(
        .N_BTN        (N),
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_raw  (btn_raw),
        .repeat_en(repeat_en),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Level flips after DEB+1 consecutive synchronized samples disagreeing with it.
    // While pressed and not releasing, r counts enabled cycles; pulses fall at
    // r = RD, RD+RP, RD+2RP, ...
    task automatic model_edge();
        logic sy;
        m_pls = '0;
        if (!rstn) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0;
            for (int i = 0; i < N; i++) begin
                m_dc[i] = 0;
                m_r[i]  = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                sy = m_s2[i];
                if (!m_lvl[i]) begin
                    if (sy) begin
                        m_dc[i]++;
                        if (m_dc[i] == DEB + 1) begin
                            m_lvl[i] = 1'b1; m_pls[i] = 1'b1; m_dc[i] = 0; m_r[i] = 0;
                        end
                    end else begin
                        m_dc[i] = 0;
                    end
                end else if (!sy) begin
                    m_r[i] = 0;
                    m_dc[i]++;
                    if (m_dc[i] == DEB + 1) begin
                        m_lvl[i] = 1'b0; m_dc[i] = 0;
                    end
                end else if (m_dc[i] != 0) begin
                    m_dc[i] = 0; m_r[i] = 0;
                end else if (repeat_en[i]) begin
                    m_r[i]++;
                    if (m_r[i] >= RD && ((m_r[i] - RD) % RP) == 0) m_pls[i] = 1'b1;
                end else begin
                    m_r[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("model_level", 32'(btn_level), 32'(m_lvl));
        check_eq("model_pulse", 32'(btn_pulse), 32'(m_pls));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int pc;
        int seen;
        int q[$];
        int exp_rep[3];
        exp_rep[0] = 7; exp_rep[1] = 17; exp_rep[2] = 20;
        for (int i = 0; i < N; i++) begin
            m_dc[i] = 0;
            m_r[i]  = 0;
        end

        // 1. reset with all buttons pressed
        rstn = 1'b0; btn_raw = 4'hF; repeat_en = '0;
        idle(2);
        check_eq("rst_level", 32'(btn_level), 32'h0);
        check_eq("rst_pulse", 32'(btn_pulse), 32'h0);
        rstn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_eq("rst_rel_pulse", 32'(btn_pulse), (k == 7) ? 32'hF : 32'h0);
        end
        btn_raw = '0;
        idle(12);

        // 2. clean press on channel 0
        btn_raw[0] = 1'b1; pc = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (btn_pulse[0]) pc++;
            if (k == 6) check_eq("press_lvl_e6", 32'(btn_level[0]), 32'h0);
            if (k == 7) check_eq("press_pulse_e7", 32'(btn_pulse[0]), 32'h1);
            if (k == 7) check_eq("press_lvl_e7", 32'(btn_level[0]), 32'h1);
        end
        check_eq("press_count", 32'(pc), 32'h1);
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("release_lvl", 32'(btn_level[0]), (k >= 7) ? 32'h0 : 32'h1);
        end
        idle(4);

        // 3. bounce rejection, then press with release bounce on channel 1
        pc = 0; seen = 0;
        for (int k = 0; k < 24; k++) begin
            btn_raw[1] = (k < 4) ? ~k[0] : 1'b0;
            tick();
            if (btn_pulse[1]) pc++;
            if (btn_level[1]) seen++;
        end
        check_eq("bounce_pulses", 32'(pc), 32'h0);
        check_eq("bounce_level", 32'(seen), 32'h0);
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (btn_pulse[1]) pc++;
        end
        for (int k = 0; k < 17; k++) begin
            btn_raw[1] = (k == 1) ? 1'b1 : 1'b0;
            tick();
            if (btn_pulse[1]) pc++;
        end
        check_eq("relbounce_pulses", 32'(pc), 32'h1);
        check_eq("relbounce_level", 32'(btn_level[1]), 32'h0);

        // 4. auto-repeat on channel 2, enable dropped before edge 21
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            repeat_en[2] = (k >= 21) ? 1'b0 : 1'b1;
            tick();
            if (btn_pulse[2]) q.push_back(k);
        end
        check_eq("rep_count", 32'(q.size()), 32'd3);
        for (int j = 0; j < 3; j++)
            check_eq("rep_edge", (j < q.size()) ? 32'(q[j]) : 32'h0, 32'(exp_rep[j]));
        check_eq("rep_level", 32'(btn_level[2]), 32'h1);
        btn_raw[2] = 1'b0; repeat_en[2] = 1'b0;
        idle(12);

        // 5. simultaneous presses
        btn_raw = 4'b1001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq("simul_pulse", 32'(btn_pulse), (k == 7) ? 32'h9 : 32'h0);
        end
        btn_raw = '0;
        idle(12);

        // 6. reset while channel 3 is auto-repeating
        btn_raw[3] = 1'b1; repeat_en[3] = 1'b1;
        idle(25);
        rstn = 1'b0;
        tick();
        check_eq("midrst_level", 32'(btn_level), 32'h0);
        check_eq("midrst_pulse", 32'(btn_pulse), 32'h0);
        rstn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_eq("midrst_repress", 32'(btn_pulse[3]), (k == 7) ? 32'h1 : 32'h0);
        end
        btn_raw = '0; repeat_en = '0;
        idle(12);

        // 7. random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
                if ($urandom_range(0, 63) == 0) repeat_en[i] = ~repeat_en[i];
            end
            rstn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
